multicycle_control_unit: RTL and testbench

//  Multicycle sequencer for the ARM datapath: one shared memory port and one ALU used over several cycles per instruction.

---
 rtl/multicycle_control_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control sequencer: decodes the held instruction, keeps NZCV and drives datapath
// enables. Optional BL link step is enabled by defining MCU_BRANCH_LINK_EN.
module multicycle_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] Flags,
   output logic       Fault
);

   localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluOrr = 2'b11;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
`ifdef MCU_BRANCH_LINK_EN
      StLink,
`endif
      StFault
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] wait_q, wait_d;
   logic [3:0]      flags_q, flags_d;
   logic            cond_ex_q, cond_ex_d;
   logic            fault_q, fault_d;

   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_b, alu_control;
   logic       alu_src_a, link_sel, waiting, cond_now;

   logic [1:0] alu_op;
   logic       is_cmp, alu_arith;

   // ARM condition field evaluated against the stored NZCV.
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: cond_holds = z;
         4'b0001: cond_holds = ~z;
         4'b0010: cond_holds = cf;
         4'b0011: cond_holds = ~cf;
         4'b0100: cond_holds = n;
         4'b0101: cond_holds = ~n;
         4'b0110: cond_holds = v;
         4'b0111: cond_holds = ~v;
         4'b1000: cond_holds = cf & ~z;
         4'b1001: cond_holds = ~cf | z;
         4'b1010: cond_holds = (n == v);
         4'b1011: cond_holds = (n != v);
         4'b1100: cond_holds = ~z & (n == v);
         4'b1101: cond_holds = z | (n != v);
         4'b1110: cond_holds = 1'b1;
         default: cond_holds = 1'b0;
      endcase
   endfunction

   always_comb begin
      alu_op = AluAdd;
      is_cmp = 1'b0;
      case (Funct[4:1])
         4'b0100: alu_op = AluAdd;
         4'b0010: alu_op = AluSub;
         4'b0000: alu_op = AluAnd;
         4'b1100: alu_op = AluOrr;
         4'b1010: begin
            alu_op = AluSub;
            is_cmp = 1'b1;
         end
         default: alu_op = AluAdd;
      endcase
      alu_arith = (alu_op == AluAdd) || (alu_op == AluSub);
   end

   assign cond_now = cond_holds(Cond, flags_q);

   always_comb begin
      state_d     = state_q;
      flags_d     = flags_q;
      cond_ex_d   = cond_ex_q;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = AluAdd;
      link_sel    = 1'b0;
      waiting     = 1'b0;

      unique case (state_q)
         StFetch: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = MemReady;
            pc_write   = MemReady;
            waiting    = 1'b1;
            if (MemReady) state_d = StDecode;
         end
         StDecode: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            cond_ex_d  = cond_now;
            if (!cond_now) begin
               state_d = StFetch;
            end else begin
               case (Op)
                  2'b01: state_d = StMemAdr;
`ifdef MCU_BRANCH_LINK_EN
                  2'b10: state_d = Funct[4] ? StLink : StBranch;
`else
                  2'b10: state_d = StBranch;
`endif
                  2'b00: state_d = Funct[5] ? StExecI : StExecR;
                  default: state_d = StFetch;
               endcase
            end
         end
         StMemAdr: begin
            alu_src_b = 2'b01;
            state_d   = Funct[0] ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            adr_src = 1'b1;
            waiting = 1'b1;
            if (MemReady) state_d = StMemWb;
         end
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            waiting   = 1'b1;
            if (MemReady) state_d = StFetch;
         end
         StExecR, StExecI: begin
            alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
            alu_control = alu_op;
            // Logical ops leave C and V untouched.
            if (cond_ex_q && Funct[0]) begin
               flags_d[3:2] = ALUFlags[3:2];
               if (alu_arith) flags_d[1:0] = ALUFlags[1:0];
            end
            state_d = StAluWb;
         end
         StAluWb: begin
            if (!is_cmp) begin
               if (Rd == 4'd15) pc_write = 1'b1;
               else reg_write = 1'b1;
            end
            state_d = StFetch;
         end
         StBranch: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = StFetch;
         end
`ifdef MCU_BRANCH_LINK_EN
         StLink: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = AluSub;
            result_src  = 2'b10;
            reg_write   = 1'b1;
            link_sel    = 1'b1;
            state_d     = StBranch;
         end
`endif
         StFault: state_d = StFault;
         default: state_d = StFetch;
      endcase

      if (waiting && !MemReady && (MEM_TIMEOUT != 0) &&
          ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT)) begin
         state_d = StFault;
      end
   end

   always_comb begin
      wait_d = '0;
      if (waiting && !MemReady && (state_d == state_q)) begin
         wait_d = (&wait_q) ? wait_q : wait_q + CntW'(1);
      end
      fault_d = fault_q | (state_d == StFault);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StFetch;
         wait_q    <= '0;
         flags_q   <= RESET_FLAGS;
         cond_ex_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
         fault_q   <= fault_d;
      end
   end

   // Strobes are forced low while reset is held, even though FETCH is already selected.
   assign PCWrite    = RST & pc_write;
   assign MemWrite   = RST & mem_write;
   assign IRWrite    = RST & ir_write;
   assign RegWrite   = RST & reg_write;
   assign AdrSrc     = adr_src;
   assign ResultSrc  = result_src;
   assign ALUSrcA    = alu_src_a;
   assign ALUSrcB    = alu_src_b;
   assign ALUControl = alu_control;
   assign ImmSrc     = Op;
   assign RegSrc     = {Op == 2'b01, (Op == 2'b10) | link_sel};
   assign Flags      = flags_q;
   assign Fault      = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instruction classes, stalls, timeout and
// reset cases, checking strobes, control selects and flags each cycle.
module tb_multicycle_control_unit;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Fault;
   logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
   logic [3:0] Flags;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_control_unit #(
      .MEM_TIMEOUT(16),
      .RESET_FLAGS(4'b0010)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Cond      (Cond),
      .Op        (Op),
      .Funct     (Funct),
      .Rd        (Rd),
      .ALUFlags  (ALUFlags),
      .MemReady  (MemReady),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUControl(ALUControl),
      .ImmSrc    (ImmSrc),
      .RegSrc    (RegSrc),
      .Flags     (Flags),
      .Fault     (Fault)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe order {PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc}.
   task automatic chk_s(input string tag, input logic [4:0] exp);
      chk(tag, 8'({PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc}), 8'(exp));
   endtask

   // Select order {ALUSrcA, ALUSrcB, ALUControl, ResultSrc}.
   task automatic chk_c(input string tag, input logic [6:0] exp);
      chk(tag, 8'({ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'(exp));
   endtask

   task automatic chk_f(input string tag, input logic [3:0] exp);
      chk(tag, 8'(Flags), 8'(exp));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(input logic mr, input logic [3:0] af);
      MemReady = mr;
      ALUFlags = af;
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r);
      Cond  = c;
      Op    = o;
      Funct = f;
      Rd    = r;
   endtask

   initial begin
      RST = 1'b0;
      MemReady = 1'b1;
      ALUFlags = 4'b0000;
      set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
      #12;
      chk_s("rst_strobes", 5'b00000);
      chk_f("rst_flags", 4'b0010);
      chk("rst_fault", 8'(Fault), 8'h0);
      tick();
      RST = 1'b1;

      // ADD R1,R2,R3
      cyc(1, 4'h0); chk_s("add_fetch", 5'b10100); chk_c("add_fetch_c", 7'b1100010); tick();
      cyc(1, 4'h0); chk_s("add_dec", 5'b00000); chk_c("add_dec_c", 7'b1100010); tick();
      cyc(1, 4'h0); chk_s("add_exec", 5'b00000); chk_c("add_exec_c", 7'b0000000); tick();
      cyc(1, 4'h0); chk_s("add_wb", 5'b00010); chk_c("add_wb_c", 7'b0000000); tick();

      // LDR with three stall cycles in MEMREAD
      set_instr(4'b1110, 2'b01, 6'b011001, 4'd4);
      cyc(1, 4'h0); chk_s("ldr_fetch", 5'b10100);
      chk("ldr_imm_reg", 8'({ImmSrc, RegSrc}), 8'b0110); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); chk_s("ldr_adr", 5'b00000); chk_c("ldr_adr_c", 7'b0010000); tick();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'h0); chk_s("ldr_wait", 5'b00001); tick();
      end
      cyc(1, 4'h0); chk_s("ldr_ready", 5'b00001); tick();
      cyc(1, 4'h0); chk_s("ldr_wb", 5'b00010); chk_c("ldr_wb_c", 7'b0000001); tick();

      // SUBS giving Z=1, then taken BEQ
      set_instr(4'b1110, 2'b00, 6'b000101, 4'd2);
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'b0100); chk_c("subs_exec_c", 7'b0000100); tick();
      cyc(1, 4'h0); chk_s("subs_wb", 5'b00010); chk_f("subs_flags", 4'b0100); tick();
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      cyc(1, 4'h0); chk_s("beq_fetch", 5'b10100); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); chk_s("beq_branch", 5'b10000); chk_c("beq_branch_c", 7'b0010010); tick();

      // ADDS clearing all flags
      set_instr(4'b1110, 2'b00, 6'b001001, 4'd3);
      cyc(1, 4'h0); chk_s("beq_lat3", 5'b10100); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'b0000); tick();
      cyc(1, 4'h0); chk_f("adds_flags", 4'b0000); tick();

      // BEQ not taken: straight back to FETCH
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); chk_s("beq_nt_dec", 5'b00000); tick();

      // ADDS skipped by EQ with Z=0: no flag update
      set_instr(4'b0000, 2'b00, 6'b001001, 4'd3);
      cyc(1, 4'h0); chk_s("beq_nt_fetch", 5'b10100); tick();
      cyc(1, 4'b1111); tick();
      cyc(1, 4'b1111); chk_s("skip_fetch", 5'b10100); chk_f("skip_flags", 4'b0000);

      // CMP R1,R1
      set_instr(4'b1110, 2'b00, 6'b010101, 4'd0);
      tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'b0110); chk_c("cmp_exec_c", 7'b0000100); tick();
      cyc(1, 4'h0); chk_s("cmp_wb", 5'b00000); chk_f("cmp_flags", 4'b0110); tick();

      // ORRS immediate: only N,Z taken
      set_instr(4'b1110, 2'b00, 6'b111001, 4'd5);
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'b1011); chk_c("orrs_exec_c", 7'b0011100); tick();
      cyc(1, 4'h0); chk_s("orrs_wb", 5'b00010); chk_f("orrs_flags", 4'b1010); tick();

      // AND immediate to R15 without S
      set_instr(4'b1110, 2'b00, 6'b100000, 4'd15);
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'b0101); chk_c("and_exec_c", 7'b0011000); tick();
      cyc(1, 4'h0); chk_s("and_pc_wb", 5'b10000); chk_f("and_flags", 4'b1010); tick();

      // BL
      set_instr(4'b1110, 2'b10, 6'b110000, 4'd0);
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); tick();
`ifdef MCU_BRANCH_LINK_EN
      cyc(1, 4'h0); chk_s("bl_link", 5'b00010); chk_c("bl_link_c", 7'b1100110);
      chk("bl_regsrc", 8'(RegSrc), 8'b01); tick();
`endif
      cyc(1, 4'h0); chk_s("bl_branch", 5'b10000); tick();

      // STR stalled, then reset mid-MEMWRITE
      set_instr(4'b1110, 2'b01, 6'b011000, 4'd1);
      cyc(1, 4'h0); chk_s("bl_next_fetch", 5'b10100); tick();
      cyc(1, 4'h0); tick();
      cyc(1, 4'h0); tick();
      cyc(0, 4'h0); chk_s("str_wait", 5'b01001); tick();
      cyc(0, 4'h0); chk_s("str_wait2", 5'b01001);
      RST = 1'b0;
      #1;
      chk_s("str_rst_async", 5'b00000);
      chk_f("str_rst_flags", 4'b0010);
      tick();
      RST = 1'b1;

      // MemReady held low in FETCH until timeout
      for (int i = 0; i < 16; i++) begin
         cyc(0, 4'h0);
         if (i == 0) chk_s("to_fetch_wait", 5'b00000);
         if (i == 15) chk("pre_timeout", 8'(Fault), 8'h0);
         tick();
      end
      cyc(1, 4'h0); chk("timeout_fault", 8'(Fault), 8'h1); chk_s("fault_strobes", 5'b00000);
      tick();
      cyc(1, 4'h0); chk_s("fault_hold", 5'b00000); chk("fault_sticky", 8'(Fault), 8'h1);
      RST = 1'b0;
      #1;
      chk("fault_rst", 8'(Fault), 8'h0);
      tick();
      RST = 1'b1;
      cyc(1, 4'h0); chk_s("post_fault_fetch", 5'b10100); chk_f("post_fault_flags", 4'b0010);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
